// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract controller.
// The requester uses the master modport; the controller uses the slave modport.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one shared full adder steps through WIDTH bits,
// LSB first, and presents a registered result with a one-cycle done pulse.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_co;

  full_adder u_fa (
    .a_i  (opa_q[0]),
    .b_i  (opb_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH steps.
  assign res_d = {fa_s, res_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // Subtract is a + ~b + 1; the +1 comes from the preset carry.
            opa_q   <= bus.a;
            opb_q   <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          res_q   <= res_d;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // On the MSB step carry_q is the carry into the MSB.
            sum_q   <= res_d;
            cout_q  <= fa_co;
            ovf_q   <= carry_q ^ fa_co;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8, plus model sweeps at WIDTH=2 and WIDTH=16.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8))  b8 ();
  serial_adder_ctrl_if #(.WIDTH(2))  b2 ();
  serial_adder_ctrl_if #(.WIDTH(16)) b16 ();

  serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder_ctrl #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(b2));
  serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 operation; optionally scrambles inputs and pulses start while running.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [7:0] es, input logic ec, input logic eo, input bit mangle);
    int nb;
    bit seen;
    @(negedge clk);
    b8.start = 1'b1; b8.a = a; b8.b = b; b8.sub = s;
    @(negedge clk);
    b8.start = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (b8.done) begin
        seen = 1'b1;
      end else begin
        if (b8.busy) nb++;
        if (mangle) begin
          b8.a = 8'($urandom); b8.b = 8'($urandom); b8.sub = 1'($urandom);
          b8.start = i[0];
        end
        @(negedge clk);
      end
    end
    b8.start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_busy_cycles"}, 64'(nb), 64'd8);
    chk({tag, "_busy_at_done"}, 64'(b8.busy), 64'd0);
    chk({tag, "_sum"}, 64'(b8.sum), 64'(es));
    chk({tag, "_cout"}, 64'(b8.cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(b8.overflow), 64'(eo));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(b8.done), 64'd0);
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic s);
    logic [2:0] full;
    logic [1:0] bb;
    logic       eo;
    int         nb;
    bit         seen;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 3'(s);
    eo   = (a[1] == bb[1]) && (full[1] != a[1]);
    @(negedge clk);
    b2.start = 1'b1; b2.a = a; b2.b = b; b2.sub = s;
    @(negedge clk);
    b2.start = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (b2.done) seen = 1'b1;
      else begin
        if (b2.busy) nb++;
        @(negedge clk);
      end
    end
    chk("w2_done_seen", 64'(seen), 64'd1);
    chk("w2_busy_cycles", 64'(nb), 64'd2);
    chk("w2_sum", 64'(b2.sum), 64'(full[1:0]));
    chk("w2_cout", 64'(b2.cout), 64'(full[2]));
    chk("w2_ovf", 64'(b2.overflow), 64'(eo));
    @(negedge clk);
    chk("w2_done_pulse", 64'(b2.done), 64'd0);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16:0] full;
    logic [15:0] bb;
    logic        eo;
    int          nb;
    bit          seen;
    bb   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + 17'(s);
    eo   = (a[15] == bb[15]) && (full[15] != a[15]);
    @(negedge clk);
    b16.start = 1'b1; b16.a = a; b16.b = b; b16.sub = s;
    @(negedge clk);
    b16.start = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (b16.done) seen = 1'b1;
      else begin
        if (b16.busy) nb++;
        @(negedge clk);
      end
    end
    chk("w16_done_seen", 64'(seen), 64'd1);
    chk("w16_busy_cycles", 64'(nb), 64'd16);
    chk("w16_sum", 64'(b16.sum), 64'(full[15:0]));
    chk("w16_cout", 64'(b16.cout), 64'(full[16]));
    chk("w16_ovf", 64'(b16.overflow), 64'(eo));
    @(negedge clk);
    chk("w16_done_pulse", 64'(b16.done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int dones;
    rst_n = 1'b0;
    b8.start = 1'b0;  b8.sub = 1'b0;  b8.a = '0;  b8.b = '0;
    b2.start = 1'b0;  b2.sub = 1'b0;  b2.a = '0;  b2.b = '0;
    b16.start = 1'b0; b16.sub = 1'b0; b16.a = '0; b16.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(b8.busy), 64'd0);
    chk("rst_done", 64'(b8.done), 64'd0);
    chk("rst_sum", 64'(b8.sum), 64'd0);
    chk("rst_cout", 64'(b8.cout), 64'd0);
    chk("rst_ovf", 64'(b8.overflow), 64'd0);
    rst_n = 1'b1;

    run8("add_basic", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    run8("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run8("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

    // Abort an operation with an asynchronous reset between clock edges.
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'h05; b8.b = 8'h03; b8.sub = 1'b0;
    @(negedge clk);
    b8.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(b8.busy), 64'd0);
    chk("abort_done", 64'(b8.done), 64'd0);
    chk("abort_sum", 64'(b8.sum), 64'd0);
    chk("abort_ovf", 64'(b8.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (b8.done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_idle_busy", 64'(b8.busy), 64'd0);

    run8("sub_neg", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    run8("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    run8("sub_zero", 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    run8("add_scramble", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 1'b1);
    run8("sub_scramble", 8'h40, 8'h10, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1);

    // Start held high: each done cycle re-accepts, giving a WIDTH+1 period.
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'h10; b8.b = 8'h20; b8.sub = 1'b0;
    t = 0;
    while (!b8.done && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("cont_first_done", 64'(b8.done), 64'd1);
    chk("cont_first_sum", 64'(b8.sum), 64'h30);
    for (int k = 0; k < 2; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!b8.done && t < 30);
      chk("cont_period", 64'(t), 64'd9);
      chk("cont_sum", 64'(b8.sum), 64'h30);
      chk("cont_busy_at_done", 64'(b8.busy), 64'd0);
    end
    @(negedge clk);
    b8.start = 1'b0;
    chk("cont_reaccept_busy", 64'(b8.busy), 64'd1);
    t = 0;
    while (!b8.done && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk("cont_last_done", 64'(b8.done), 64'd1);
    @(negedge clk);
    chk("cont_idle_busy", 64'(b8.busy), 64'd0);
    chk("cont_idle_done", 64'(b8.done), 64'd0);

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int s = 0; s < 2; s++)
          run2(2'(a), 2'(b), 1'(s));

    run16(16'hFFFF, 16'h0001, 1'b0);
    run16(16'h8000, 16'h0001, 1'b1);
    for (int i = 0; i < 10; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller that time-shares a single FullAdder cell across a WIDTH-bit operation, one bit per clock, LSB first. It is the sequencing block for the CPU's minimal-area ALU path. It latches operands on a start handshake, steps the shared FullAdder through the bits with a carry flip-flop and shift registers, and presents a registered result with a one-cycle done pulse.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is WIDTH >= 2.
CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request a new operation; sampled on the rising edge of clk.
sub  input  1  0 = a+b, 1 = a-b; sampled only when start is accepted.
a  input  WIDTH  operand A; sampled only when start is accepted.
b  input  WIDTH  operand B; sampled only when start is accepted.
busy  output  1  high while bits are being processed (RUN state).
done  output  1  one-cycle pulse; result is valid from this cycle onward.
sum  output  WIDTH  registered result (a+b or a-b, modulo 2^WIDTH).
cout  output  1  final carry out; in subtract mode, 1 = no borrow (a >= b unsigned).
overflow  output  1  signed two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0.
  - Internal shift registers, the carry flip-flop and the counter also clear to 0.
  - Reset asserted mid-operation aborts it: no done pulse is produced, and the previous result is lost (outputs read 0).
- Datapath: exactly one FullAdder instance.
  - A=opA[0], B=opB[0], Ci=carry_q.
  - Each RUN cycle: S shifts into res[WIDTH-1]; opA and opB shift right by 1; carry_q<=Co.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge k -> opA<=a; opB<=sub ? ~b : b; carry_q<=sub; cnt<=0; go to RUN. busy=1 from edge k.
  - RUN: one bit per edge; cnt increments each edge.
    - On the edge where cnt==WIDTH-1 (edge k+WIDTH): sum<=final shifted result; cout<=Co; overflow<=carry_q^Co; go to DONE.
    - start is ignored throughout RUN.
  - DONE: done=1, busy=0 for exactly one cycle.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation, no idle bubble). Otherwise go to IDLE.
- Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- Signal relationships: busy and done are never high together.
- Output hold:
  - sum, cout and overflow update only on the final RUN edge.
  - They hold their previous values during RUN and IDLE until the next completion.
- Operand capture: a, b and sub changing after acceptance have no effect on the operation in flight.
- Arithmetic: all results are modulo 2^WIDTH.
  - Subtract is a + ~b + 1, with the +1 supplied by the initial carry.
  - a=b=0 with sub=1 gives sum=0, cout=1, overflow=0.

Test Plan:
1. Reset mid-operation: start a=8'h05, b=8'h03, assert rst_n=0 after 3 cycles -> busy=0, done=0, sum=0 immediately (asynchronously); no done pulse appears after reset is released.
2. Basic add: a=8'h05, b=8'h03, sub=0, start pulse -> busy high for 8 cycles; done pulse 8 edges after start; sum=8'h08, cout=0, overflow=0.
3. Carry wrap: a=8'hFF, b=8'h01, add -> sum=8'h00, cout=1, overflow=0. Then a=8'h7F, b=8'h01, add -> sum=8'h80, cout=0, overflow=1.
4. Subtract: a=8'h03, b=8'h05, sub=1 -> sum=8'hFE, cout=0, overflow=0. Then a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, cout=1, overflow=1.
5. Handshake:
   - Hold start=1 continuously with a=8'h10, b=8'h20 -> done every 9 cycles; re-accept occurs in DONE; sum=8'h30.
   - Toggle a, b and sub during RUN -> result unchanged.
   - Pulse start during RUN -> ignored.
6. Parameter sweep at WIDTH=2 and WIDTH=16: random operands compared against a behavioural model.
   - Check sum, cout and overflow against the model.
   - busy width equals WIDTH.
   - done is a single-cycle pulse.
